// File: rtl/parking_gate_ctrl.sv
// Parking gate front-end: conditions the raw gate sensors and badge readers,
// runs the entrance/exit barrier FSMs, emits clean one-cycle car_entered /
// car_exited events and keeps the time of day for the occupancy block.
module parking_gate_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GATE_TIMEOUT    = 50,
    parameter int TIMER_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_minute,
    input  logic       ent_sensor,
    input  logic       ent_badge,
    input  logic       ex_sensor,
    input  logic       ex_badge,
    input  logic       uni_is_vacated_space,
    input  logic       is_vacated_space,
    output logic       car_entered,
    output logic       is_uni_car_entered,
    output logic       car_exited,
    output logic       is_uni_car_exited,
    output logic [5:0] current_hour,
    output logic [5:0] current_minute,
    output logic       ent_gate_open,
    output logic       ex_gate_open,
    output logic       ent_denied
);

    localparam logic [TIMER_W-1:0] DB_LAST = TIMER_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TO_LAST = TIMER_W'(GATE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ENT_IDLE, ENT_DECIDE, ENT_OPEN, ENT_DENY, ENT_CLEAR
    } ent_st_t;

    typedef enum logic [1:0] {
        EX_IDLE, EX_OPEN, EX_CLEAR
    } ex_st_t;

    // raw inputs packed as {ex_badge, ex_sensor, ent_badge, ent_sensor}
    logic [3:0]              w_raw;
    logic [3:0]              r_sync1, r_sync2;
    // index 0 = entrance sensor, 1 = exit sensor
    logic [1:0]              w_sens_s;
    logic [1:0][TIMER_W-1:0] r_db_cnt;
    logic [1:0]              r_filt, r_filt_d;
    logic [1:0]              w_rise, w_fall;

    ent_st_t                 r_ent_st, w_ent_nxt;
    ex_st_t                  r_ex_st, w_ex_nxt;
    logic [TIMER_W-1:0]      r_ent_tmr, r_ex_tmr;
    logic                    r_ent_uni, r_ex_uni;
    logic                    w_ent_latch, w_ex_latch;
    logic                    w_ent_req, w_ex_req;
    logic                    r_pend, r_pend_uni;
    logic [5:0]              r_min, r_hour;

    assign w_raw    = {ex_badge, ex_sensor, ent_badge, ent_sensor};
    assign w_sens_s = {r_sync2[2], r_sync2[0]};
    assign w_rise   = r_filt & ~r_filt_d;
    assign w_fall   = ~r_filt & r_filt_d;

    // two-flop synchronizer for every asynchronous sensor/badge input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // debounce: accept a new level only after it has been stable long enough;
    // any return to the filtered level restarts the count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db_cnt <= '0;
            r_filt   <= '0;
            r_filt_d <= '0;
        end else begin
            r_filt_d <= r_filt;
            for (int i = 0; i < 2; i++) begin
                if (w_sens_s[i] != r_filt[i]) begin
                    if (r_db_cnt[i] == DB_LAST) begin
                        r_filt[i]   <= w_sens_s[i];
                        r_db_cnt[i] <= '0;
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                    end
                end else begin
                    r_db_cnt[i] <= '0;
                end
            end
        end
    end

    // time of day: minute 0..59, hour 0..23
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_min  <= '0;
            r_hour <= '0;
        end else if (tick_minute) begin
            if (r_min == 6'd59) begin
                r_min  <= '0;
                r_hour <= (r_hour == 6'd23) ? 6'd0 : r_hour + 1'b1;
            end else begin
                r_min <= r_min + 1'b1;
            end
        end
    end

    // FSM state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ent_st <= ENT_IDLE;
            r_ex_st  <= EX_IDLE;
        end else begin
            r_ent_st <= w_ent_nxt;
            r_ex_st  <= w_ex_nxt;
        end
    end

    // entrance next-state: vacancy flags only matter in DECIDE
    always_comb begin
        w_ent_nxt   = r_ent_st;
        w_ent_req   = 1'b0;
        w_ent_latch = 1'b0;
        case (r_ent_st)
            ENT_IDLE: begin
                if (w_rise[0]) begin
                    w_ent_latch = 1'b1;
                    w_ent_nxt   = ENT_DECIDE;
                end
            end
            ENT_DECIDE: begin
                // a car gone before the decision just returns to idle
                if (w_fall[0])
                    w_ent_nxt = ENT_IDLE;
                else if (r_ent_uni ? uni_is_vacated_space : is_vacated_space)
                    w_ent_nxt = ENT_OPEN;
                else
                    w_ent_nxt = ENT_DENY;
            end
            ENT_OPEN: begin
                if (w_fall[0]) begin
                    w_ent_req = 1'b1;
                    w_ent_nxt = ENT_IDLE;
                end else if (r_ent_tmr == TO_LAST) begin
                    w_ent_nxt = ENT_CLEAR;
                end
            end
            ENT_DENY, ENT_CLEAR: begin
                if (w_fall[0])
                    w_ent_nxt = ENT_IDLE;
            end
            default: w_ent_nxt = ENT_IDLE;
        endcase
    end

    // exit next-state: exit is always granted
    always_comb begin
        w_ex_nxt   = r_ex_st;
        w_ex_req   = 1'b0;
        w_ex_latch = 1'b0;
        case (r_ex_st)
            EX_IDLE: begin
                if (w_rise[1]) begin
                    w_ex_latch = 1'b1;
                    w_ex_nxt   = EX_OPEN;
                end
            end
            EX_OPEN: begin
                if (w_fall[1]) begin
                    w_ex_req = 1'b1;
                    w_ex_nxt = EX_IDLE;
                end else if (r_ex_tmr == TO_LAST) begin
                    w_ex_nxt = EX_CLEAR;
                end
            end
            EX_CLEAR: begin
                if (w_fall[1])
                    w_ex_nxt = EX_IDLE;
            end
            default: w_ex_nxt = EX_IDLE;
        endcase
    end

    // open-gate timeout counters (zero whenever the gate is not open) and badge latches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ent_tmr <= '0;
            r_ex_tmr  <= '0;
            r_ent_uni <= 1'b0;
            r_ex_uni  <= 1'b0;
        end else begin
            r_ent_tmr <= (r_ent_st == ENT_OPEN) ? r_ent_tmr + 1'b1 : '0;
            r_ex_tmr  <= (r_ex_st == EX_OPEN) ? r_ex_tmr + 1'b1 : '0;
            if (w_ent_latch) r_ent_uni <= r_sync2[1];
            if (w_ex_latch)  r_ex_uni  <= r_sync2[3];
        end
    end

    // event stage: exit wins a same-cycle collision, entry waits one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            car_entered        <= 1'b0;
            is_uni_car_entered <= 1'b0;
            car_exited         <= 1'b0;
            is_uni_car_exited  <= 1'b0;
            r_pend             <= 1'b0;
            r_pend_uni         <= 1'b0;
        end else begin
            car_exited        <= w_ex_req;
            is_uni_car_exited <= w_ex_req & r_ex_uni;
            car_entered        <= 1'b0;
            is_uni_car_entered <= 1'b0;
            if (r_pend) begin
                car_entered        <= 1'b1;
                is_uni_car_entered <= r_pend_uni;
                r_pend             <= 1'b0;
            end else if (w_ent_req && w_ex_req) begin
                r_pend     <= 1'b1;
                r_pend_uni <= r_ent_uni;
            end else if (w_ent_req) begin
                car_entered        <= 1'b1;
                is_uni_car_entered <= r_ent_uni;
            end
        end
    end

    assign current_minute = r_min;
    assign current_hour   = r_hour;
    assign ent_gate_open  = (r_ent_st == ENT_OPEN);
    assign ent_denied     = (r_ent_st == ENT_DENY);
    assign ex_gate_open   = (r_ex_st == EX_OPEN);

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl: a scoreboard queue holds expected
// entry/exit events (type, qualifier, cycle); a negedge monitor pops them.
module tb_parking_gate_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_minute = 1'b0;
    logic       ent_sensor = 1'b0, ent_badge = 1'b0;
    logic       ex_sensor = 1'b0, ex_badge = 1'b0;
    logic       uni_is_vacated_space = 1'b0, is_vacated_space = 1'b0;
    logic       car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
    logic [5:0] current_hour, current_minute;
    logic       ent_gate_open, ex_gate_open, ent_denied;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        bit ex;
        bit uni;
        int cyc;
    } ev_t;
    ev_t sb[$];

    parking_gate_ctrl dut (
        .clk                  (clk),
        .rst                  (rst),
        .tick_minute          (tick_minute),
        .ent_sensor           (ent_sensor),
        .ent_badge            (ent_badge),
        .ex_sensor            (ex_sensor),
        .ex_badge             (ex_badge),
        .uni_is_vacated_space (uni_is_vacated_space),
        .is_vacated_space     (is_vacated_space),
        .car_entered          (car_entered),
        .is_uni_car_entered   (is_uni_car_entered),
        .car_exited           (car_exited),
        .is_uni_car_exited    (is_uni_car_exited),
        .current_hour         (current_hour),
        .current_minute       (current_minute),
        .ent_gate_open        (ent_gate_open),
        .ex_gate_open         (ex_gate_open),
        .ent_denied           (ent_denied)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // advance n clock edges, leaving time just after the last edge
    task automatic tk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic see_ev(input bit ex, input bit uni);
        ev_t e;
        if (sb.size() == 0) begin
            chk(ex ? "unexpected_exit" : "unexpected_entry", sb.size(), 1);
        end else begin
            e = sb.pop_front();
            chk("ev_type", int'(ex), int'(e.ex));
            chk("ev_uni", int'(uni), int'(e.uni));
            chk("ev_cycle", cyc, e.cyc);
        end
    endtask

    // event monitor
    always @(negedge clk) begin
        chk("no_overlap", int'(car_entered & car_exited), 0);
        chk("ent_qual_idle", int'(is_uni_car_entered & ~car_entered), 0);
        chk("ex_qual_idle", int'(is_uni_car_exited & ~car_exited), 0);
        if (car_exited)  see_ev(1'b1, is_uni_car_exited);
        if (car_entered) see_ev(1'b0, is_uni_car_entered);
    end

    initial begin
        // reset state
        tk(3);
        chk("rst_entered", car_entered, 0);
        chk("rst_exited", car_exited, 0);
        chk("rst_ent_gate", ent_gate_open, 0);
        chk("rst_ex_gate", ex_gate_open, 0);
        chk("rst_denied", ent_denied, 0);
        chk("rst_hour", current_hour, 0);
        chk("rst_min", current_minute, 0);
        rst = 1'b0;
        tk(2);

        // time of day: 60 ticks -> 01:00, 23*60 more -> 00:00
        tick_minute = 1'b1;
        tk(59);
        chk("t59_min", current_minute, 59);
        chk("t59_hour", current_hour, 0);
        tk(1);
        chk("t60_min", current_minute, 0);
        chk("t60_hour", current_hour, 1);
        tk(23 * 60 - 1);
        chk("t2359_min", current_minute, 59);
        chk("t2359_hour", current_hour, 23);
        tk(1);
        chk("wrap_min", current_minute, 0);
        chk("wrap_hour", current_hour, 0);
        tick_minute = 1'b0;

        // uni car granted: gate 8 cycles after rise, event 7 after fall
        ent_badge = 1'b1; uni_is_vacated_space = 1'b1; is_vacated_space = 1'b0;
        tk(4);
        ent_sensor = 1'b1;
        tk(7);
        chk("uni_gate_early", ent_gate_open, 0);
        tk(1);
        chk("uni_gate_open", ent_gate_open, 1);
        tk(12);
        ent_sensor = 1'b0;
        sb.push_back('{ex: 1'b0, uni: 1'b1, cyc: cyc + 7});
        tk(6);
        chk("uni_gate_hold", ent_gate_open, 1);
        tk(1);
        chk("uni_gate_closed", ent_gate_open, 0);
        tk(5);

        // non-uni, no vacancy (uni vacancy present must not help); glitch first
        ent_badge = 1'b0; is_vacated_space = 1'b0; uni_is_vacated_space = 1'b1;
        tk(4);
        ent_sensor = 1'b1;
        tk(3);
        ent_sensor = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tk(1);
            chk("glitch_denied", ent_denied, 0);
            chk("glitch_gate", ent_gate_open, 0);
        end
        ent_sensor = 1'b1;
        tk(7);
        chk("deny_early", ent_denied, 0);
        tk(1);
        chk("deny_on", ent_denied, 1);
        chk("deny_gate", ent_gate_open, 0);
        tk(12);
        ent_sensor = 1'b0;
        tk(6);
        chk("deny_hold", ent_denied, 1);
        tk(1);
        chk("deny_off", ent_denied, 0);
        tk(5);

        // stalled car: gate open 50 cycles, then closed, no event
        is_vacated_space = 1'b1;
        tk(2);
        ent_sensor = 1'b1;
        tk(8);
        chk("to_gate_open", ent_gate_open, 1);
        tk(49);
        chk("to_gate_last", ent_gate_open, 1);
        tk(1);
        chk("to_gate_closed", ent_gate_open, 0);
        tk(41);
        chk("to_still_closed", ent_gate_open, 0);
        chk("to_no_deny", ent_denied, 0);
        ent_sensor = 1'b0;
        tk(10);
        chk("to_after_fall", ent_gate_open, 0);

        // simultaneous falls: exit at N, entry at N+1
        ex_badge = 1'b1; ent_badge = 1'b0; is_vacated_space = 1'b1;
        tk(4);
        ent_sensor = 1'b1; ex_sensor = 1'b1;
        tk(6);
        chk("ex_gate_early", ex_gate_open, 0);
        tk(1);
        chk("ex_gate_open", ex_gate_open, 1);
        tk(13);
        ent_sensor = 1'b0; ex_sensor = 1'b0;
        sb.push_back('{ex: 1'b1, uni: 1'b1, cyc: cyc + 7});
        sb.push_back('{ex: 1'b0, uni: 1'b0, cyc: cyc + 8});
        tk(15);
        chk("ex_gate_closed", ex_gate_open, 0);

        // reset in the middle of an open entrance transaction
        tick_minute = 1'b1;
        tk(5);
        tick_minute = 1'b0;
        chk("pre_rst_min", current_minute, 5);
        ent_sensor = 1'b1;
        tk(10);
        chk("pre_rst_gate", ent_gate_open, 1);
        rst = 1'b1;
        #1;
        chk("rst_async_gate", ent_gate_open, 0);
        chk("rst_async_min", current_minute, 0);
        tk(2);
        rst = 1'b0;
        ent_sensor = 1'b0;
        tk(20);
        chk("post_rst_gate", ent_gate_open, 0);
        chk("post_rst_deny", ent_denied, 0);

        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/parking_gate_ctrl.md
Name: parking_gate_ctrl

Overview:
- Front-end controller that feeds the parking occupancy block.
- Turns raw entrance/exit gate sensors and badge readers into clean one-cycle car_entered / car_exited events with uni/non-uni qualifiers.
- Drives both barriers, and maintains the time of day that supplies current_hour to the occupancy block.
- Uses the occupancy block's vacancy flags to grant or deny entry.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized cycles before a sensor change is accepted.
- GATE_TIMEOUT, 50: cycles a barrier stays open waiting for the car to pass before aborting.
- TIMER_W, 8: width of the debounce and timeout counters; must hold max(DEBOUNCE_CYCLES, GATE_TIMEOUT).

Ports:
- clk  in  1  system clock; one clock only.
- rst  in  1  asynchronous, active-high reset.
- tick_minute  in  1  one-cycle pulse per simulated minute.
- ent_sensor  in  1  raw entrance loop sensor; asynchronous.
- ent_badge  in  1  raw entrance badge, 1 = uni car; held while the car is present.
- ex_sensor  in  1  raw exit loop sensor; asynchronous.
- ex_badge  in  1  raw exit badge, 1 = uni car.
- uni_is_vacated_space  in  1  from occupancy block.
- is_vacated_space  in  1  from occupancy block.
- car_entered  out  1  one-cycle entry event.
- is_uni_car_entered  out  1  qualifier; valid only while car_entered = 1, else 0.
- car_exited  out  1  one-cycle exit event.
- is_uni_car_exited  out  1  qualifier; valid only while car_exited = 1, else 0.
- current_hour  out  6  0..23.
- current_minute  out  6  0..59.
- ent_gate_open  out  1  entrance barrier raised.
- ex_gate_open  out  1  exit barrier raised.
- ent_denied  out  1  entry refused (no vacancy).

Behaviour:
- Reset (asynchronous, any time, including mid-transaction):
  - All outputs go to 0; time is 00:00.
  - Both FSMs go to IDLE; debounce filters clear to 0; the pending-entry flag clears.
  - No event is emitted for an interrupted transaction.
- Input conditioning:
  - Every raw input (sensors, badges) passes a 2-flop synchronizer.
  - Each sensor then has a debounce filter: the filtered value changes only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles. Any glitch restarts the count.
  - Raw-to-filtered latency = 2 + DEBOUNCE_CYCLES cycles.
  - A rise or fall of the filtered signal is a one-cycle internal edge strobe.
- Time of day:
  - On tick_minute, minute increments; 59 wraps to 0 and increments hour; hour 23 wraps to 0.
  - Outputs are registered and update the cycle after the tick.
- Entrance FSM states: IDLE, DECIDE, OPEN, DENY, CLEAR.
  - IDLE: on filtered ent_sensor rise, latch the synchronized ent_badge, then go to DECIDE.
  - DECIDE (one cycle), evaluating the vacancy inputs in this cycle:
    - Grant if (badge=1 and uni_is_vacated_space=1) or (badge=0 and is_vacated_space=1); go to OPEN.
    - Otherwise go to DENY.
  - OPEN: ent_gate_open=1; the timeout counter counts from 0.
    - On filtered sensor fall: request an entry event with the latched badge, then go to IDLE.
    - On counter reaching GATE_TIMEOUT-1 with the sensor still high: abort, no event, go to CLEAR.
  - DENY: ent_denied=1 until filtered sensor fall, then go to IDLE.
  - CLEAR: gate closed; wait for filtered sensor fall, then go to IDLE. Prevents re-triggering by a stalled car.
- Exit FSM states: IDLE, OPEN, CLEAR.
  - Exit is always granted.
  - IDLE: on rise, latch ex_badge and go to OPEN; ex_gate_open rises the next cycle.
  - OPEN: ex_gate_open=1. On fall, request an exit event; on timeout, go to CLEAR with no event.
  - CLEAR: as for the entrance.
- Event output stage:
  - car_entered and car_exited are registered and asserted for exactly one cycle per completed transaction.
  - The event appears the cycle after the FSM sees the filtered fall.
  - If entry and exit events are requested in the same cycle: exit is emitted first; entry is held in a one-deep pending flag and emitted the next cycle. Both events are never asserted together.
  - A new entry request cannot arrive while entry is pending, since the FSM needs at least DEBOUNCE_CYCLES to re-arm.
- Vacancy inputs are sampled only in DECIDE; changes in any other state are ignored.

Test Plan:
- Reset, then 60 tick_minute pulses -> current_minute=0, current_hour=1; after a further 23*60 ticks -> 00:00.
- Uni car at entrance: ent_badge=1, uni_is_vacated_space=1, ent_sensor high for 20 cycles then low -> ent_gate_open rises 8 cycles after the sensor rise. Exactly one cycle of car_entered=1 with is_uni_car_entered=1, 7 cycles after the sensor fall.
- Non-uni car with is_vacated_space=0 -> ent_denied=1 while the sensor is high, no gate, no car_entered; 3-cycle sensor glitches produce no FSM activity.
- Entrance sensor held high 100 cycles -> gate open for 50 cycles then closed, no event; no new transaction until the sensor drops and rises again.
- Exit and entrance sensors fall in the same cycle -> car_exited pulse at cycle N, car_entered pulse at N+1, never overlapping.
- rst asserted while ent_gate_open=1 -> gate and all outputs 0 immediately; the later sensor fall produces no event.
